// File: rtl/touch_led_array.sv
// touch_led_array: per-channel touch synchroniser/debouncer with press strobes and
// mode-selected LED drive (toggle, follow, one-shot, off), all in the sys_clk domain.
module touch_led_array #(
  parameter int CH            = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYC       = 1000000,
  parameter int PULSE_CYC     = 25000000,
  parameter bit TOUCH_ACT_LOW = 1'b1,
  parameter bit LED_ACT_LOW   = 1'b1
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [CH-1:0]   touch_in,
  input  logic [2*CH-1:0] mode,
  output logic [CH-1:0]   press_pulse,
  output logic [CH-1:0]   touch_state,
  output logic [CH-1:0]   led_out
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int PW = $clog2(PULSE_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [PW-1:0] PULSE_LD = PW'(PULSE_CYC);
  logic [CH-1:0] touched;
  assign touched = TOUCH_ACT_LOW ? ~touch_in : touch_in;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          deb_cnt;
    logic [PW-1:0]          pcnt, pcnt_nxt;
    logic [1:0]             m;
    logic                   stable, stable_d, tog, tog_nxt, press, pulse, led, lit;
    // LED is registered from the next-state toggle/pulse values so it moves with press_pulse
    always_comb begin
      m        = mode[2*i +: 2];
      press    = stable & ~stable_d;
      tog_nxt  = tog ^ press;
      pcnt_nxt = press ? PULSE_LD : (pcnt != '0 ? pcnt - 1'b1 : pcnt);
      lit      = m == 2'b00 ? tog_nxt :
                 m == 2'b01 ? stable :
                 m == 2'b10 ? pcnt_nxt != '0 : 1'b0;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        sync     <= '0;
        deb_cnt  <= '0;
        stable   <= 1'b0;
        stable_d <= 1'b0;
        tog      <= 1'b0;
        pcnt     <= '0;
        pulse    <= 1'b0;
        led      <= LED_ACT_LOW;
      end else begin
        sync     <= {sync[SYNC_STAGES-2:0], touched[i]};
        stable_d <= stable;
        tog      <= tog_nxt;
        pcnt     <= pcnt_nxt;
        pulse    <= press;
        led      <= lit ^ LED_ACT_LOW;
        if (sync[SYNC_STAGES-1] == stable) deb_cnt <= '0;
        else if (deb_cnt == DEB_LAST) begin
          deb_cnt <= '0;
          stable  <= ~stable;
        end else deb_cnt <= deb_cnt + 1'b1;
      end
    assign press_pulse[i] = pulse;
    assign touch_state[i] = stable;
    assign led_out[i]     = led;
  end
endmodule
